// File: rtl/nmr_acq_capture.sv
`default_nettype none
// ============================================================================
//  Module   : nmr_acq_capture
//  Purpose  : Acquisition capture stage behind the NMR pulse program. ADC
//             samples that arrive inside an ACQ_WND window are tagged with the
//             echo index and an end-of-window marker, buffered in a FIFO and
//             presented on a valid/ready stream. Echoes per scan are counted;
//             FIFO overflow is flagged and scan completion is pulsed on DONE.
//  Ports    : CLK, RESET (async, active-low)
//             START, ECHO_PER_SCAN          - scan control
//             ACQ_WND, ADC_STB, ADC_DATA    - window and sample input
//             M_DATA/M_ECHO/M_LAST/M_VALID/M_READY - output stream
//             ECHO_COUNT, SAMPLE_COUNT, OVERFLOW, BUSY, DONE - status
//  Revision : 1.0 - initial release
// ============================================================================
module nmr_acq_capture #(
  parameter int ADC_WIDTH      = 14,
  parameter int FIFO_DEPTH     = 1024,
  parameter int ECHO_CNT_WIDTH = 16
) (
  input  logic                      CLK,
  input  logic                      RESET,
  input  logic                      START,
  input  logic [31:0]               ECHO_PER_SCAN,
  input  logic                      ACQ_WND,
  input  logic                      ADC_STB,
  input  logic [ADC_WIDTH-1:0]      ADC_DATA,
  output logic [ADC_WIDTH-1:0]      M_DATA,
  output logic [ECHO_CNT_WIDTH-1:0] M_ECHO,
  output logic                      M_LAST,
  output logic                      M_VALID,
  input  logic                      M_READY,
  output logic [ECHO_CNT_WIDTH-1:0] ECHO_COUNT,
  output logic [31:0]               SAMPLE_COUNT,
  output logic                      OVERFLOW,
  output logic                      BUSY,
  output logic                      DONE
);

  localparam int          AW       = $clog2(FIFO_DEPTH);
  localparam int          WORD_W   = ADC_WIDTH + ECHO_CNT_WIDTH + 1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ARMED   = 2'd1;
  localparam logic [1:0] S_CAPTURE = 2'd2;

  logic [1:0]                state_q, state_d;
  logic [31:0]               eps_q, eps_d;
  logic [ECHO_CNT_WIDTH-1:0] echo_count_q, echo_count_d;
  logic [31:0]               sample_count_q, sample_count_d;
  logic                      overflow_q, overflow_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;
  logic                      zero_done_q, zero_done_d;
  logic                      hold_valid_q, hold_valid_d;
  logic [ADC_WIDTH-1:0]      hold_data_q, hold_data_d;
  logic [ECHO_CNT_WIDTH-1:0] hold_echo_q, hold_echo_d;
  logic [AW-1:0]             wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, head_idx;
  logic [AW:0]               fifo_cnt_q, fifo_cnt_d, cnt_after_pop;
  logic                      m_valid_q, m_valid_d;
  logic [WORD_W-1:0]         m_word_q, m_word_d;
  logic [WORD_W-1:0]         mem_q [FIFO_DEPTH];

  logic              scan_end, accept, win_fall;
  logic              push, push_ok, pop, fifo_full;
  logic [WORD_W-1:0] push_word;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    if (START) begin
      state_d = (ECHO_PER_SCAN == 32'd0) ? S_IDLE : S_ARMED;
    end else begin
      case (state_q)
        S_ARMED: begin
          if (scan_end)     state_d = S_IDLE;
          else if (ACQ_WND) state_d = S_CAPTURE;
        end
        S_CAPTURE: if (!ACQ_WND) state_d = S_ARMED;
        default:   state_d = S_IDLE;
      endcase
    end
  end

  // ---------------- FSM: outputs / decodes ----------------
  // The echo counter is bumped on the window's falling edge; the scan ends one
  // cycle later when ARMED sees the target reached. Samples are refused in that
  // cycle so they cannot leak into a finished scan.
  always_comb begin
    scan_end = (state_q == S_ARMED) && (32'(echo_count_q) == eps_q);
    accept   = !START && ADC_STB && ACQ_WND &&
               ((state_q == S_CAPTURE) || ((state_q == S_ARMED) && !scan_end));
    win_fall = !START && (state_q == S_CAPTURE) && !ACQ_WND;
    if (START) busy_d = (state_q != S_IDLE) && (ECHO_PER_SCAN != 32'd0);
    else       busy_d = (state_q != S_IDLE) && !scan_end;
    done_d   = !START && (scan_end || zero_done_q);
  end

  // ---------------- Hold register, counters ----------------
  // One-entry hold delays each sample until we know whether it is the last
  // of its window (next sample arrives -> LAST=0, window falls -> LAST=1).
  always_comb begin
    eps_d          = eps_q;
    echo_count_d   = echo_count_q;
    sample_count_d = sample_count_q;
    overflow_d     = overflow_q;
    zero_done_d    = 1'b0;
    hold_valid_d   = hold_valid_q;
    hold_data_d    = hold_data_q;
    hold_echo_d    = hold_echo_q;
    push           = 1'b0;
    push_word      = {hold_data_q, hold_echo_q, 1'b0};
    if (START) begin
      eps_d          = ECHO_PER_SCAN;
      echo_count_d   = '0;
      sample_count_d = '0;
      overflow_d     = 1'b0;
      hold_valid_d   = 1'b0;
      hold_data_d    = '0;
      hold_echo_d    = '0;
      zero_done_d    = (ECHO_PER_SCAN == 32'd0);
    end else begin
      if (accept) begin
        sample_count_d = sample_count_q + 32'd1;
        push           = hold_valid_q;
        hold_valid_d   = 1'b1;
        hold_data_d    = ADC_DATA;
        hold_echo_d    = echo_count_q;
      end
      if (win_fall) begin
        echo_count_d = echo_count_q + ECHO_CNT_WIDTH'(1);
        push         = hold_valid_q;
        push_word[0] = 1'b1;
        hold_valid_d = 1'b0;
      end
      if (push && fifo_full) overflow_d = 1'b1;
    end
  end

  // ---------------- FIFO with registered FWFT output ----------------
  // The output register mirrors the head entry, which stays counted in
  // fifo_cnt until consumed, so total capacity is exactly FIFO_DEPTH.
  assign fifo_full = (fifo_cnt_q == FULL_CNT);

  always_comb begin
    pop           = m_valid_q && M_READY;
    push_ok       = push && !fifo_full;
    head_idx      = rd_ptr_q + AW'(pop);
    wr_ptr_d      = wr_ptr_q + AW'(push_ok);
    rd_ptr_d      = head_idx;
    fifo_cnt_d    = fifo_cnt_q + (AW+1)'(push_ok) - (AW+1)'(pop);
    cnt_after_pop = fifo_cnt_q - (AW+1)'(pop);
    m_valid_d     = m_valid_q;
    m_word_d      = m_word_q;
    if (!m_valid_q || M_READY) begin
      m_valid_d = (cnt_after_pop != '0);
      if (cnt_after_pop != '0) m_word_d = mem_q[head_idx];
    end
    if (START) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      fifo_cnt_d = '0;
      m_valid_d  = 1'b0;
      m_word_d   = '0;
    end
  end

  always_ff @(posedge CLK) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_word;
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      eps_q          <= '0;
      echo_count_q   <= '0;
      sample_count_q <= '0;
      overflow_q     <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      zero_done_q    <= 1'b0;
      hold_valid_q   <= 1'b0;
      hold_data_q    <= '0;
      hold_echo_q    <= '0;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      fifo_cnt_q     <= '0;
      m_valid_q      <= 1'b0;
      m_word_q       <= '0;
    end else begin
      eps_q          <= eps_d;
      echo_count_q   <= echo_count_d;
      sample_count_q <= sample_count_d;
      overflow_q     <= overflow_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      zero_done_q    <= zero_done_d;
      hold_valid_q   <= hold_valid_d;
      hold_data_q    <= hold_data_d;
      hold_echo_q    <= hold_echo_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      fifo_cnt_q     <= fifo_cnt_d;
      m_valid_q      <= m_valid_d;
      m_word_q       <= m_word_d;
    end
  end

  assign M_DATA       = m_word_q[WORD_W-1 -: ADC_WIDTH];
  assign M_ECHO       = m_word_q[ECHO_CNT_WIDTH:1];
  assign M_LAST       = m_word_q[0];
  assign M_VALID      = m_valid_q;
  assign ECHO_COUNT   = echo_count_q;
  assign SAMPLE_COUNT = sample_count_q;
  assign OVERFLOW     = overflow_q;
  assign BUSY         = busy_q;
  assign DONE         = done_q;

endmodule
`default_nettype wire

// File: tb/tb_nmr_acq_capture.sv
`default_nettype none
// ============================================================================
//  Module   : tb_nmr_acq_capture
//  Purpose  : Directed self-checking bench for nmr_acq_capture (FIFO_DEPTH=4).
//             Expected output words are queued as stimulus is driven and
//             compared as the DUT delivers them.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_nmr_acq_capture;

  localparam int ADC_W = 14;
  localparam int ECW   = 16;

  logic             CLK = 1'b0;
  logic             RESET = 1'b0;
  logic             START = 1'b0;
  logic [31:0]      ECHO_PER_SCAN = '0;
  logic             ACQ_WND = 1'b0;
  logic             ADC_STB = 1'b0;
  logic [ADC_W-1:0] ADC_DATA = '0;
  logic [ADC_W-1:0] M_DATA;
  logic [ECW-1:0]   M_ECHO;
  logic             M_LAST;
  logic             M_VALID;
  logic             M_READY = 1'b1;
  logic [ECW-1:0]   ECHO_COUNT;
  logic [31:0]      SAMPLE_COUNT;
  logic             OVERFLOW;
  logic             BUSY;
  logic             DONE;

  int checks   = 0;
  int failures = 0;

  logic [ADC_W+ECW:0] sb [$];
  logic [ECW-1:0]     exp_echo = '0;
  bit                 toggle_rdy = 1'b0;
  bit                 stall_prev = 1'b0;
  logic [ADC_W+ECW:0] stall_word = '0;

  nmr_acq_capture #(.ADC_WIDTH(ADC_W), .FIFO_DEPTH(4), .ECHO_CNT_WIDTH(ECW)) dut (
    .CLK(CLK), .RESET(RESET), .START(START), .ECHO_PER_SCAN(ECHO_PER_SCAN),
    .ACQ_WND(ACQ_WND), .ADC_STB(ADC_STB), .ADC_DATA(ADC_DATA),
    .M_DATA(M_DATA), .M_ECHO(M_ECHO), .M_LAST(M_LAST), .M_VALID(M_VALID),
    .M_READY(M_READY), .ECHO_COUNT(ECHO_COUNT), .SAMPLE_COUNT(SAMPLE_COUNT),
    .OVERFLOW(OVERFLOW), .BUSY(BUSY), .DONE(DONE)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Output monitor: scoreboard compare on each handshake, stall stability.
  always @(negedge CLK) begin
    if (!RESET) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev)
        check("stall_hold", {M_VALID, M_DATA, M_ECHO, M_LAST}, {1'b1, stall_word});
      if (M_VALID && M_READY) begin
        check("word_expected", 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) check("word", {M_DATA, M_ECHO, M_LAST}, sb.pop_front());
      end
      stall_prev = M_VALID && !M_READY;
      stall_word = {M_DATA, M_ECHO, M_LAST};
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
    if (toggle_rdy) M_READY = !M_READY;
  endtask

  task automatic start(input logic [31:0] eps);
    ECHO_PER_SCAN = eps;
    START = 1'b1;
    exp_echo = '0;
    tick();
    START = 1'b0;
  endtask

  // Opens a window with n back-to-back strobes; the first 'keep' samples are
  // expected at the output. Optionally strobes on the first low cycle.
  task automatic window(input int n, input logic [ADC_W-1:0] base, input int keep,
                        input bit fall_stb);
    ACQ_WND = 1'b1;
    for (int i = 0; i < n; i++) begin
      ADC_STB  = 1'b1;
      ADC_DATA = base + ADC_W'(i);
      if (i < keep) sb.push_back({ADC_DATA, exp_echo, (i == n - 1)});
      tick();
    end
    ADC_STB  = fall_stb;
    ADC_DATA = base + ADC_W'(15);
    ACQ_WND  = 1'b0;
    tick();
    ADC_STB  = 1'b0;
    exp_echo = exp_echo + 1'b1;
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && (sb.size() != 0 || M_VALID); i++) tick();
    check("drain_empty", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    // ---- reset values ----
    repeat (3) tick();
    check("rst_stream", {M_DATA, M_ECHO, M_LAST, M_VALID}, '0);
    check("rst_status", {ECHO_COUNT, OVERFLOW, BUSY, DONE}, '0);
    check("rst_samples", SAMPLE_COUNT, '0);
    RESET = 1'b1;
    tick();

    // ---- two windows of three samples ----
    start(2);
    check("t1_busy_t", BUSY, 0);
    tick();
    check("t1_busy_t1", BUSY, 1);
    window(3, 14'd1, 3, 1'b0);
    check("t1_echo1", ECHO_COUNT, 1);
    tick();
    window(3, 14'd4, 3, 1'b0);
    check("t1_echo2", ECHO_COUNT, 2);
    check("t1_done_w", {DONE, BUSY}, 2'b01);
    tick();
    check("t1_done_w1", {DONE, BUSY}, 2'b10);
    tick();
    check("t1_done_w2", DONE, 0);
    drain();
    check("t1_samples", SAMPLE_COUNT, 6);

    // ---- strobes on window fall cycle and in IDLE ignored ----
    start(1);
    tick();
    window(2, 14'h10, 2, 1'b1);
    tick();
    tick();
    ACQ_WND = 1'b1; ADC_STB = 1'b1; ADC_DATA = 14'h1E;
    tick();
    tick();
    ACQ_WND = 1'b0; ADC_STB = 1'b0;
    drain();
    check("t2_samples", SAMPLE_COUNT, 2);
    check("t2_echo", ECHO_COUNT, 1);
    check("t2_busy", BUSY, 0);

    // ---- overflow with consumer stalled ----
    M_READY = 1'b0;
    start(1);
    tick();
    window(7, 14'h20, 4, 1'b0);
    tick();
    tick();
    check("t3_overflow", OVERFLOW, 1);
    check("t3_samples", SAMPLE_COUNT, 7);
    check("t3_head", {M_VALID, M_DATA}, {1'b1, 14'h20});
    M_READY = 1'b1;
    drain();
    check("t3_valid_after", M_VALID, 0);

    // ---- ready toggling every cycle ----
    start(2);
    check("t4_ovf_cleared", OVERFLOW, 0);
    toggle_rdy = 1'b1;
    tick();
    window(4, 14'h30, 4, 1'b0);
    tick();
    window(3, 14'h40, 3, 1'b0);
    tick();
    tick();
    drain();
    toggle_rdy = 1'b0;
    M_READY = 1'b1;
    check("t4_echo", ECHO_COUNT, 2);
    check("t4_samples", SAMPLE_COUNT, 7);

    // ---- zero echoes per scan, then an empty window ----
    start(0);
    check("t5_zero_t", {DONE, BUSY}, 2'b00);
    tick();
    check("t5_zero_t1", {DONE, BUSY}, 2'b10);
    tick();
    check("t5_zero_t2", {DONE, BUSY}, 2'b00);
    start(1);
    ACQ_WND = 1'b1;
    tick();
    tick();
    ACQ_WND = 1'b0;
    tick();
    check("t5_empty_echo", ECHO_COUNT, 1);
    tick();
    check("t5_empty_done", DONE, 1);
    tick();
    check("t5_empty_novalid", M_VALID, 0);
    check("t5_empty_samples", SAMPLE_COUNT, 0);

    // ---- reset mid-window with FIFO nonempty ----
    M_READY = 1'b0;
    start(2);
    tick();
    ACQ_WND = 1'b1;
    for (int i = 0; i < 3; i++) begin
      ADC_STB = 1'b1;
      ADC_DATA = 14'h60 + ADC_W'(i);
      tick();
    end
    ADC_STB = 1'b0;
    tick();
    check("t6_pre_valid", M_VALID, 1);
    #2;
    RESET = 1'b0;
    #1;
    check("t6_rst_stream", {M_DATA, M_ECHO, M_LAST, M_VALID}, '0);
    check("t6_rst_status", {ECHO_COUNT, SAMPLE_COUNT, OVERFLOW, BUSY, DONE}, '0);
    ACQ_WND = 1'b0;
    tick();
    tick();
    RESET = 1'b1;
    M_READY = 1'b1;
    tick();
    start(1);
    tick();
    window(2, 14'h50, 2, 1'b0);
    tick();
    tick();
    drain();
    check("t6_samples", SAMPLE_COUNT, 2);
    check("t6_echo", ECHO_COUNT, 1);
    check("t6_busy", BUSY, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
